// File: rtl/debug_pkg.sv
// Shared types and constants for the debug-side register dump logic.
package debug_pkg;

    localparam int BYTE_W         = 8;
    localparam int DEFAULT_DATA_W = 32;
    localparam int BYTES_PER_WORD = DEFAULT_DATA_W / BYTE_W;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE     = 3'd0;
    localparam state_t ST_WAIT     = 3'd1;
    localparam state_t ST_SEND     = 3'd2;
    localparam state_t ST_DONE     = 3'd3;
    localparam state_t ST_CHECKSUM = 3'd4;

    function automatic int bytes_per_word(input int data_w);
        return data_w / BYTE_W;
    endfunction

endpackage

// File: rtl/regfile_dump_reader_if.sv
// Register-file read port plus byte stream towards the UART transmitter.
interface regfile_dump_reader_if
    import debug_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] o_rd_addr;
    logic [DATA_W-1:0] i_rd_data;
    logic [BYTE_W-1:0] o_tx_data;
    logic              o_tx_valid;
    logic              i_tx_ready;

    modport master (
        output o_rd_addr,
        output o_tx_data,
        output o_tx_valid,
        input  i_rd_data,
        input  i_tx_ready
    );

    modport slave (
        input  o_rd_addr,
        input  o_tx_data,
        input  o_tx_valid,
        output i_rd_data,
        output i_tx_ready
    );
endinterface

// File: rtl/word_byte_serializer.sv
// Holds one register word and hands it out MSB byte first, flagging the final byte.
module word_byte_serializer
    import debug_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              load,
    input  logic [DATA_W-1:0] load_word,
    input  logic              shift,
    output logic [BYTE_W-1:0] byte_out,
    output logic              last
);
    localparam int BPW   = bytes_per_word(DATA_W);
    localparam int IDX_W = (BPW > 1) ? $clog2(BPW) : 1;

    logic [DATA_W-1:0] word;
    logic [IDX_W-1:0]  idx;

    // Load has priority over shift; the FSM never asserts both in one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word <= '0;
            idx  <= '0;
        end else if (clear) begin
            word <= '0;
            idx  <= '0;
        end else if (load) begin
            word <= load_word;
            idx  <= '0;
        end else if (shift) begin
            word <= word << BYTE_W;
            idx  <= idx + IDX_W'(1);
        end
    end

    assign byte_out = word[DATA_W-1 -: BYTE_W];
    assign last     = (idx == IDX_W'(BPW - 1));

endmodule

// File: rtl/regfile_dump_reader.sv
// Walks all registers through one read port and streams them MSB-first as bytes.
// Define REGDUMP_CHECKSUM_EN to append an XOR checksum byte after the last register.
module regfile_dump_reader
    import debug_pkg::*;
#(
    parameter int N_REGS = 32,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    regfile_dump_reader_if.master bus,
    output logic                  o_busy,
    output logic                  o_done
);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_REGS - 1);

    state_t            state;
    logic [ADDR_W-1:0] rd_addr;
    logic              handshake;
    logic              ser_last;
    logic [BYTE_W-1:0] ser_byte;
    logic              start_ok;

    assign start_ok  = (state == ST_IDLE) && i_start;
    assign handshake = bus.o_tx_valid && bus.i_tx_ready;

    word_byte_serializer #(.DATA_W(DATA_W)) u_ser (
        .clk       (clk),
        .rst_n     (i_rst_n),
        .clear     (start_ok),
        .load      (state == ST_WAIT),
        .load_word (bus.i_rd_data),
        .shift     ((state == ST_SEND) && handshake),
        .byte_out  (ser_byte),
        .last      (ser_last)
    );

    // The read port data for rd_addr settles on the falling edge, so WAIT can capture it.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= ST_IDLE;
            rd_addr <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_start) begin
                        rd_addr <= '0;
                        state   <= ST_WAIT;
                    end
                end
                ST_WAIT: state <= ST_SEND;
                ST_SEND: begin
                    if (handshake && ser_last) begin
                        if (rd_addr == LAST_ADDR) begin
`ifdef REGDUMP_CHECKSUM_EN
                            state <= ST_CHECKSUM;
`else
                            state <= ST_DONE;
`endif
                        end else begin
                            rd_addr <= rd_addr + ADDR_W'(1);
                            state   <= ST_WAIT;
                        end
                    end
                end
`ifdef REGDUMP_CHECKSUM_EN
                ST_CHECKSUM: begin
                    if (handshake) state <= ST_DONE;
                end
`endif
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef REGDUMP_CHECKSUM_EN
    logic [BYTE_W-1:0] checksum;

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            checksum <= '0;
        end else if (start_ok) begin
            checksum <= '0;
        end else if ((state == ST_SEND) && handshake) begin
            checksum <= checksum ^ ser_byte;
        end
    end

    assign bus.o_tx_data  = (state == ST_CHECKSUM) ? checksum : ser_byte;
    assign bus.o_tx_valid = (state == ST_SEND) || (state == ST_CHECKSUM);
`else
    assign bus.o_tx_data  = ser_byte;
    assign bus.o_tx_valid = (state == ST_SEND);
`endif

    assign bus.o_rd_addr = rd_addr;
    assign o_busy        = (state != ST_IDLE);
    assign o_done        = (state == ST_DONE);

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Self-checking bench for regfile_dump_reader: the expected byte stream is built from the register image.
// Define REGDUMP_CHECKSUM_EN for both bench and RTL to expect the trailing XOR byte.
`timescale 1ns/1ps
module tb_regfile_dump_reader;
    localparam int N_REGS     = 32;
    localparam int ADDR_W     = 5;
    localparam int DATA_W     = 32;
    localparam int WORD_BYTES = DATA_W / 8;
    localparam int DATA_BYTES = N_REGS * WORD_BYTES;
`ifdef REGDUMP_CHECKSUM_EN
    localparam int TOTAL_BYTES = DATA_BYTES + 1;
`else
    localparam int TOTAL_BYTES = DATA_BYTES;
`endif
    // One WAIT per register, one cycle per byte, plus the DONE cycle itself.
    localparam int DUMP_CYCLES = N_REGS + TOTAL_BYTES + 1;

    logic clk;
    logic rst_n;
    logic i_start;
    logic o_busy;
    logic o_done;

    regfile_dump_reader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    regfile_dump_reader #(.N_REGS(N_REGS), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk     (clk),
        .i_rst_n (rst_n),
        .i_start (i_start),
        .bus     (bus),
        .o_busy  (o_busy),
        .o_done  (o_done)
    );

    logic [31:0] regs [N_REGS];
    logic [7:0]  expQ [$];
    logic [7:0]  gotQ [$];
    int          checkCount;
    int          failCount;
    int          readyMode;
    int          sentCount;
    int          stallCount;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
        checkCount++;
        if (got !== want) begin
            failCount++;
            $display("[TB] FAIL %s got=%0h want=%0h at %0t", name, got, want, $time);
        end
    endtask

    function automatic logic [7:0] xorOfImage();
        logic [7:0] x;
        x = '0;
        for (int r = 0; r < N_REGS; r++)
            for (int b = 0; b < WORD_BYTES; b++)
                x ^= regs[r][b*8 +: 8];
        return x;
    endfunction

    function automatic void buildExpected();
        expQ.delete();
        for (int r = 0; r < N_REGS; r++)
            for (int b = WORD_BYTES - 1; b >= 0; b--)
                expQ.push_back(regs[r][b*8 +: 8]);
`ifdef REGDUMP_CHECKSUM_EN
        expQ.push_back(xorOfImage());
`endif
    endfunction

    // Register file: read data follows the address on the falling edge.
    initial begin
        bus.i_rd_data = '0;
        forever begin
            @(negedge clk);
            bus.i_rd_data = regs[bus.o_rd_addr];
        end
    end

    // Transmitter ready: 0 = always ready, 1 = toggling, 2 = random.
    initial begin
        bus.i_tx_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (readyMode)
                0:       bus.i_tx_ready = 1'b1;
                1:       bus.i_tx_ready = ~bus.i_tx_ready;
                default: bus.i_tx_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Reference model: phase 0 = fetching a word, 1 = offering a byte, 2 = done pulse.
    initial begin
        bit         active;
        int         phase;
        bit         prevStall;
        logic [7:0] prevData;
        active = 0; phase = 0; prevStall = 0; prevData = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                checkOutput("rst_busy", o_busy, 0);
                checkOutput("rst_valid", bus.o_tx_valid, 0);
                checkOutput("rst_done", o_done, 0);
                checkOutput("rst_tx_data", bus.o_tx_data, 0);
                checkOutput("rst_rd_addr", bus.o_rd_addr, 0);
                active = 0; phase = 0; prevStall = 0;
            end else if (!active) begin
                checkOutput("idle_busy", o_busy, 0);
                checkOutput("idle_valid", bus.o_tx_valid, 0);
                checkOutput("idle_done", o_done, 0);
                if (i_start) begin
                    active = 1; phase = 0; sentCount = 0; prevStall = 0;
                end
            end else begin
                checkOutput("busy", o_busy, 1);
                checkOutput("valid", bus.o_tx_valid, 32'(phase == 1));
                checkOutput("done", o_done, 32'(phase == 2));
                checkOutput("rd_addr", bus.o_rd_addr,
                            (sentCount >= DATA_BYTES) ? N_REGS - 1 : sentCount / WORD_BYTES);
                case (phase)
                    0: phase = 1;
                    1: begin
                        if (sentCount < expQ.size())
                            checkOutput("tx_data", bus.o_tx_data, expQ[sentCount]);
                        if (prevStall)
                            checkOutput("stall_hold", bus.o_tx_data, prevData);
                        prevStall = !bus.i_tx_ready;
                        prevData  = bus.o_tx_data;
                        if (bus.i_tx_ready) begin
                            gotQ.push_back(bus.o_tx_data);
                            sentCount++;
                            if (sentCount == TOTAL_BYTES)
                                phase = 2;
                            else if ((sentCount % WORD_BYTES == 0) && (sentCount < DATA_BYTES))
                                phase = 0;
                        end else begin
                            stallCount++;
                        end
                    end
                    default: active = 0;
                endcase
            end
        end
    end

    // Pulses start, optionally re-pulses it mid-dump, and counts edges until o_done.
    task automatic applyStimulus(input int mode, input int extraStartAt, output int cycles);
        bit pulsed;
        pulsed     = 0;
        readyMode  = mode;
        stallCount = 0;
        gotQ.delete();
        @(posedge clk); #1 i_start = 1'b1;
        @(posedge clk); #1 i_start = 1'b0;
        cycles = 1;
        while (!o_done && cycles < 5000) begin
            @(posedge clk); #1;
            cycles++;
            if (!pulsed && extraStartAt >= 0 && sentCount >= extraStartAt) begin
                i_start = 1'b1;
                pulsed  = 1;
            end else begin
                i_start = 1'b0;
            end
        end
        i_start = 1'b0;
        checkOutput("done_seen", o_done, 1);
    endtask

    task automatic checkRunTiming(input string name, input int cycles);
        checkOutput(name, cycles, DUMP_CYCLES + stallCount);
        checkOutput("byte_count", gotQ.size(), TOTAL_BYTES);
        @(posedge clk); #1;
        checkOutput("busy_after_done", o_busy, 0);
    endtask

    initial begin
        int cycles;
        int n;
        checkCount = 0; failCount = 0; readyMode = 0;
        sentCount = 0; stallCount = 0;
        rst_n = 1'b0; i_start = 1'b0;

        for (int r = 0; r < N_REGS; r++) regs[r] = 32'h01020300 + r;
        buildExpected();
        checkOutput("model_b0", expQ[0], 8'h01);
        checkOutput("model_b3", expQ[3], 8'h00);
        checkOutput("model_b7", expQ[7], 8'h01);
        checkOutput("model_last", expQ[DATA_BYTES-1], 8'h1F);

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);

        $display("[TB] full dump, ready high");
        applyStimulus(0, -1, cycles);
        checkOutput("done_at_161", cycles, 32'(N_REGS * 5 + 1 + TOTAL_BYTES - DATA_BYTES));
        checkOutput("got_b0", gotQ[0], 8'h01);
        checkOutput("got_b1", gotQ[1], 8'h02);
        checkOutput("got_b3", gotQ[3], 8'h00);
        checkOutput("got_b7", gotQ[7], 8'h01);
        checkOutput("got_last", gotQ[DATA_BYTES-1], 8'h1F);
        checkRunTiming("latency_ready", cycles);

        $display("[TB] full dump, ready toggling");
        applyStimulus(1, -1, cycles);
        checkOutput("stalls_seen", 32'(stallCount > 0), 1);
        checkRunTiming("latency_toggle", cycles);

        $display("[TB] start re-pulsed at byte 40");
        applyStimulus(0, 40, cycles);
        checkOutput("restart_ignored", cycles, 32'(N_REGS * 5 + 1 + TOTAL_BYTES - DATA_BYTES));
        checkRunTiming("latency_restart", cycles);

        $display("[TB] reset while sending register 7");
        readyMode = 0;
        @(posedge clk); #1 i_start = 1'b1;
        @(posedge clk); #1 i_start = 1'b0;
        n = 0;
        while (sentCount < 29 && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("reached_reg7", 32'(sentCount >= 29), 1);
        #3 rst_n = 1'b0;
        #1;
        checkOutput("async_busy", o_busy, 0);
        checkOutput("async_valid", bus.o_tx_valid, 0);
        checkOutput("async_tx_data", bus.o_tx_data, 0);
        checkOutput("async_rd_addr", bus.o_rd_addr, 0);
        checkOutput("async_done", o_done, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5) @(posedge clk);
        applyStimulus(0, -1, cycles);
        checkOutput("fresh_b0", gotQ[0], 8'h01);
        checkRunTiming("latency_after_reset", cycles);

        for (int it = 0; it < 2; it++) begin
            $display("[TB] random image %0d, random ready", it);
            for (int r = 0; r < N_REGS; r++) regs[r] = $urandom;
            buildExpected();
            applyStimulus(2, -1, cycles);
            checkRunTiming("latency_random", cycles);
        end

`ifdef REGDUMP_CHECKSUM_EN
        $display("[TB] checksum, all ones");
        for (int r = 0; r < N_REGS; r++) regs[r] = 32'hFFFFFFFF;
        buildExpected();
        checkOutput("model_cs_ff", xorOfImage(), 8'h00);
        applyStimulus(0, -1, cycles);
        checkOutput("cs_ff_b0", gotQ[0], 8'hFF);
        checkOutput("cs_ff_sum", gotQ[DATA_BYTES], 8'h00);
        checkRunTiming("latency_cs_ff", cycles);

        $display("[TB] checksum, single A5");
        for (int r = 0; r < N_REGS; r++) regs[r] = 32'h0;
        regs[0] = 32'h000000A5;
        buildExpected();
        applyStimulus(1, -1, cycles);
        checkOutput("cs_a5_sum", gotQ[DATA_BYTES], 8'hA5);
        checkRunTiming("latency_cs_a5", cycles);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
